// File: rtl/arb_mux_n.sv
// -----------------------------------------------------------------------------
// arb_mux_n
// Merges N producer streams into one consumer stream. An internal arbiter
// (round-robin or fixed priority) picks one valid channel per cycle and its
// beat is captured in a single output register.
//
// Handshake rule for every channel: a beat moves on a rising clock edge where
// valid and ready are both high. Producers hold valid/data stable until that
// edge. Ready never depends on data.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   per-channel valid                              [N-1:0]
//   in_data    flattened channel data, channel i in bits
//              [i*(W+1)+W : i*(W+1)]                          [N*(W+1)-1:0]
//   in_ready   per-channel ready, one-hot or zero             [N-1:0]
//   out_valid  output register holds a beat (FSM state FULL)
//   out_data   data of the held beat                          [W:0]
//   out_chan   channel that supplied the held beat            [CW-1:0]
//   out_ready  consumer accepts the held beat
// -----------------------------------------------------------------------------
module arb_mux_n #(
    parameter int W    = 31,
    parameter int N    = 4,
    parameter int MODE = 0,
    parameter int CW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N*(W+1)-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [W:0]         out_data,
    output logic [CW-1:0]      out_chan,
    input  logic               out_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic [CW:0]   NUM_CH  = (CW+1)'(N);
    localparam logic [CW-1:0] LAST_CH = CW'(N-1);

    state_e        state_q, state_d;
    logic [W:0]    data_q, data_d;
    logic [CW-1:0] chan_q, chan_d;
    logic [CW-1:0] ptr_q, ptr_d;

    logic          grant_found;
    logic [CW-1:0] grant;
    logic [CW:0]   rr_idx;
    logic          load;
    logic [W:0]    data_sel;

    // -------------------------------------------------------------------------
    // Arbiter. Round-robin walks ptr, ptr+1, ... with an explicit wrap at N so
    // non-power-of-2 channel counts never visit a missing channel. Fixed
    // priority walks from channel 0. First valid channel found wins.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        rr_idx      = '0;
        for (int k = 0; k < N; k++) begin
            if (MODE == 0) begin
                rr_idx = {1'b0, ptr_q} + (CW+1)'(k);
                if (rr_idx >= NUM_CH) begin
                    rr_idx = rr_idx - NUM_CH;
                end
            end else begin
                rr_idx = (CW+1)'(k);
            end
            if (!grant_found && in_valid[rr_idx[CW-1:0]]) begin
                grant_found = 1'b1;
                grant       = rr_idx[CW-1:0];
            end
        end
    end

    // A new beat can be taken when the register is empty or is being popped.
    assign load = (!out_valid || out_ready) && grant_found;

    // Ready is gated by rst_n so no producer sees an accept while in reset.
    always_comb begin
        in_ready = '0;
        if (rst_n && load) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign data_sel = in_data[int'(grant)*(W+1) +: (W+1)];

    // -------------------------------------------------------------------------
    // Output-register FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output-register FSM: next state
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_FULL;
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Output-register FSM: outputs
    always_comb begin
        out_valid = (state_q == ST_FULL);
        out_data  = data_q;
        out_chan  = chan_q;
    end

    // -------------------------------------------------------------------------
    // Datapath and priority pointer. On a pop without refill the data and
    // channel registers keep their last values.
    // -------------------------------------------------------------------------
    always_comb begin
        data_d = data_q;
        chan_d = chan_q;
        ptr_d  = ptr_q;
        if (load) begin
            data_d = data_sel;
            chan_d = grant;
            if (MODE == 0) begin
                ptr_d = (grant == LAST_CH) ? '0 : grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            chan_q <= '0;
            ptr_q  <= '0;
        end else begin
            data_q <= data_d;
            chan_q <= chan_d;
            ptr_q  <= ptr_d;
        end
    end

endmodule

// File: tb/tb_arb_mux_n.sv
// -----------------------------------------------------------------------------
// tb_arb_mux_n
// Three instances share clock and reset:
//   dut0  N=4, round-robin      (reset, fairness, sparse, backpressure, reset)
//   dut1  N=4, fixed priority   (starvation then hand-over)
//   dut2  N=3, round-robin      (pointer wrap on a non-power-of-2 count)
// The driver issues one cycle of stimulus at a time with a hand-computed grant
// and pushes the expected {chan, data} beat into that instance's queue. A
// monitor per instance pops and compares each beat it sees leave the block.
// -----------------------------------------------------------------------------
module tb_arb_mux_n;

    localparam int TW = 31;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [31:0]   chdat [4];

    logic [3:0]    v0, ir0;
    logic [127:0]  d0;
    logic          ov0, ordy0;
    logic [TW:0]   od0;
    logic [1:0]    oc0;

    logic [3:0]    v1, ir1;
    logic [127:0]  d1;
    logic          ov1, ordy1;
    logic [TW:0]   od1;
    logic [1:0]    oc1;

    logic [2:0]    v2, ir2;
    logic [95:0]   d2;
    logic          ov2, ordy2;
    logic [TW:0]   od2;
    logic [1:0]    oc2;

    assign d0 = {chdat[3], chdat[2], chdat[1], chdat[0]};
    assign d1 = {chdat[3], chdat[2], chdat[1], chdat[0]};
    assign d2 = {chdat[2], chdat[1], chdat[0]};

    arb_mux_n #(.W(TW), .N(4), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(d0), .in_ready(ir0),
        .out_valid(ov0), .out_data(od0), .out_chan(oc0), .out_ready(ordy0)
    );

    arb_mux_n #(.W(TW), .N(4), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_chan(oc1), .out_ready(ordy1)
    );

    arb_mux_n #(.W(TW), .N(3), .MODE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(d2), .in_ready(ir2),
        .out_valid(ov2), .out_data(od2), .out_chan(oc2), .out_ready(ordy2)
    );

    // ---------------- scoreboard ----------------
    logic [35:0] exp0_q[$];
    logic [35:0] exp1_q[$];
    logic [35:0] exp2_q[$];
    int n_checks;
    int n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spurious(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got a beat, expected none queued", name);
    endtask

    // Monitors: a beat leaves on the edge after a negedge that sees valid&ready.
    logic [35:0] e0, e1, e2;

    always @(negedge clk) begin
        if (ov0 && ordy0) begin
            if (exp0_q.size() == 0) spurious("mon0_beat");
            else begin
                e0 = exp0_q.pop_front();
                chk("mon0_beat", 64'({2'b00, oc0, od0}), 64'(e0));
            end
        end
    end

    always @(negedge clk) begin
        if (ov1 && ordy1) begin
            if (exp1_q.size() == 0) spurious("mon1_beat");
            else begin
                e1 = exp1_q.pop_front();
                chk("mon1_beat", 64'({2'b00, oc1, od1}), 64'(e1));
            end
        end
    end

    always @(negedge clk) begin
        if (ov2 && ordy2) begin
            if (exp2_q.size() == 0) spurious("mon2_beat");
            else begin
                e2 = exp2_q.pop_front();
                chk("mon2_beat", 64'({2'b00, oc2, od2}), 64'(e2));
            end
        end
    end

    // ---------------- driver ----------------
    // Entered at posedge+1. Drives one cycle, checks ready at posedge+3,
    // queues the expected beat, and returns at the next posedge+1.
    task automatic drive_cycle(input int dut, input logic [3:0] vld,
                               input logic rdy, input int exp_g);
        logic [3:0]  exp_r;
        logic [3:0]  act_r;
        logic [35:0] item;
        case (dut)
            0: begin v0 = vld;      ordy0 = rdy; end
            1: begin v1 = vld;      ordy1 = rdy; end
            default: begin v2 = vld[2:0]; ordy2 = rdy; end
        endcase
        #2;
        exp_r = (exp_g >= 0) ? 4'(1 << exp_g) : 4'h0;
        case (dut)
            0: act_r = ir0;
            1: act_r = ir1;
            default: act_r = {1'b0, ir2};
        endcase
        chk($sformatf("in_ready_dut%0d", dut), 64'(act_r), 64'(exp_r));
        if (exp_g >= 0) begin
            item = {4'(exp_g), chdat[exp_g]};
            case (dut)
                0: exp0_q.push_back(item);
                1: exp1_q.push_back(item);
                default: exp2_q.push_back(item);
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int fair_seq [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 4; i++) chdat[i] = 32'h7E00_00A0 + 32'(i);
        v0 = 4'hF; ordy0 = 1'b1;
        v1 = 4'h0; ordy1 = 1'b1;
        v2 = 3'h0; ordy2 = 1'b1;

        // Reset with all channels requesting
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ov0), 64'(0));
        chk("rst_in_ready",  64'(ir0), 64'(0));
        chk("rst_out_data",  64'(od0), 64'(0));
        chk("rst_out_chan",  64'(oc0), 64'(0));
        rst_n = 1'b1;

        // Round-robin fairness, one beat per cycle
        for (int i = 0; i < 6; i++) begin
            drive_cycle(0, 4'hF, 1'b1, fair_seq[i]);
            chk("fair_out_valid", 64'(ov0), 64'(1));
        end

        // Sparse: ch1 and ch3 with ptr=2
        drive_cycle(0, 4'b1010, 1'b1, 3);
        drive_cycle(0, 4'b1010, 1'b1, 1);
        drive_cycle(0, 4'b0000, 1'b1, -1);
        chk("drain_out_valid", 64'(ov0), 64'(0));
        chk("drain_keep_chan", 64'(oc0), 64'(1));

        // Backpressure with a ch2 beat of 0x55, ptr then 3
        chdat[2] = 32'h0000_0055;
        drive_cycle(0, 4'b0100, 1'b1, 2);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 4'hF, 1'b0, -1);
            chk("stall_out_valid", 64'(ov0), 64'(1));
            chk("stall_out_data",  64'(od0), 64'(32'h0000_0055));
            chk("stall_out_chan",  64'(oc0), 64'(2));
        end
        drive_cycle(0, 4'hF, 1'b1, 3);
        chk("refill_out_chan", 64'(oc0), 64'(3));
        drive_cycle(0, 4'b0000, 1'b1, -1);

        // Mid-stream reset while stalled on a marked ch0 beat
        chdat[0] = 32'hDEAD_00EE;
        drive_cycle(0, 4'b0001, 1'b1, 0);
        drive_cycle(0, 4'b0000, 1'b0, -1);
        chk("pre_reset_out_valid", 64'(ov0), 64'(1));
        #1;
        v0    = 4'hF;
        ordy0 = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(ov0), 64'(0));
        chk("async_rst_in_ready",  64'(ir0), 64'(0));
        exp0_q.delete();
        chdat[0] = 32'h7E00_00A0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // ptr back at 0 selects ch0 over ch1
        drive_cycle(0, 4'b0011, 1'b1, 0);
        drive_cycle(0, 4'b0000, 1'b1, -1);

        // Fixed priority: ch3 starves until ch0 drops
        drive_cycle(1, 4'b1001, 1'b1, 0);
        drive_cycle(1, 4'b1001, 1'b1, 0);
        drive_cycle(1, 4'b1001, 1'b1, 0);
        drive_cycle(1, 4'b1000, 1'b1, 3);
        drive_cycle(1, 4'b0000, 1'b1, -1);

        // N=3: accepting ch2 wraps ptr to 0
        drive_cycle(2, 4'b0100, 1'b1, 2);
        drive_cycle(2, 4'b0111, 1'b1, 0);
        drive_cycle(2, 4'b0111, 1'b1, 1);
        drive_cycle(2, 4'b0111, 1'b1, 2);
        drive_cycle(2, 4'b0111, 1'b1, 0);
        drive_cycle(2, 4'b0000, 1'b1, -1);

        repeat (3) @(posedge clk);
        #1;
        chk("queue0_empty", 64'(exp0_q.size()), 64'(0));
        chk("queue1_empty", 64'(exp1_q.size()), 64'(0));
        chk("queue2_empty", 64'(exp2_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
